// File: rtl/attn_pkg.sv
// Shared types and constants for the linear-engine scheduler.
package attn_pkg;

  localparam int MATRIX_SIZE = 16;
  localparam int DATA_WIDTH  = 8;

  typedef logic signed [DATA_WIDTH-1:0]      elem_t;
  typedef elem_t [MATRIX_SIZE-1:0][MATRIX_SIZE-1:0] matrix_t;
  typedef elem_t [MATRIX_SIZE-1:0]           bias_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_RUN  = 3'd2,
    ST_ACK  = 3'd3,
    ST_ERR  = 3'd4
  } sched_state_e;

  // Increment an 8-bit counter, sticking at its maximum value.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

endpackage

// File: rtl/linear_sched_if.sv
// Requester-side bus: level requests, operands, grant and completion.
interface linear_sched_if #(
  parameter int NUM_REQ = 4
);
  import attn_pkg::*;

  logic [NUM_REQ-1:0]    req;
  matrix_t [NUM_REQ-1:0] mat_a;
  matrix_t [NUM_REQ-1:0] wt;
  bias_t [NUM_REQ-1:0]   bias;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    ack;
  logic                  ack_err;

  // Requesters drive the job inputs and observe grant/completion.
  modport master (
    output req, mat_a, wt, bias,
    input  gnt, ack, ack_err
  );

  // The scheduler consumes the job inputs and drives grant/completion.
  modport slave (
    input  req, mat_a, wt, bias,
    output gnt, ack, ack_err
  );

endinterface

// File: rtl/linear_sched_rr_arbiter.sv
// Round-robin pick: lowest requesting index at or after the pointer, with wrap.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic               any
);

  logic found_s;
  int   idx_s;

  // Scan NUM_REQ positions starting at the pointer; the first set request wins.
  always_comb begin
    pick    = '0;
    found_s = 1'b0;
    idx_s   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found_s && req[idx_s]) begin
        pick[idx_s] = 1'b1;
        found_s     = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/linear_sched.sv
// Scheduler sharing one linear engine among NUM_REQ requesters, with a
// per-job clear pulse, run timeout and round-robin fairness.
module linear_sched #(
  parameter int NUM_REQ     = 4,
  // Must match the package values; operand types come from attn_pkg.
  parameter int MATRIX_SIZE = attn_pkg::MATRIX_SIZE,
  parameter int DATA_WIDTH  = attn_pkg::DATA_WIDTH,
  parameter int TIMEOUT     = 4096
) (
  input  logic              clk,
  input  logic              rst,
  linear_sched_if.slave     bus,
  output attn_pkg::matrix_t res_matrix,
  output logic [7:0]        err_cnt,
  output logic              eng_rst,
  output logic              eng_start,
  output attn_pkg::matrix_t eng_mat_a,
  output attn_pkg::matrix_t eng_wt,
  output attn_pkg::bias_t   eng_bias,
  input  logic              eng_done,
  input  attn_pkg::matrix_t eng_out
);
  import attn_pkg::sched_state_e;
  import attn_pkg::ST_IDLE;
  import attn_pkg::ST_CLR;
  import attn_pkg::ST_RUN;
  import attn_pkg::ST_ACK;
  import attn_pkg::ST_ERR;
  import attn_pkg::matrix_t;
  import attn_pkg::bias_t;
  import attn_pkg::sat_inc8;

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  sched_state_e       state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               ack_err_q, ack_err_d;
  logic               eng_rst_q, eng_rst_d;
  logic               eng_start_q, eng_start_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   gnt_idx_q, gnt_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  matrix_t            res_q, res_d;
  logic [7:0]         err_cnt_q, err_cnt_d;

  logic [NUM_REQ-1:0] pick_s;
  logic               any_s;
  logic [PTR_W-1:0]   pick_idx_s;
  logic [PTR_W-1:0]   rr_ptr_next_s;
  logic               timeout_s;
  matrix_t            eng_mat_a_s;
  matrix_t            eng_wt_s;
  bias_t              eng_bias_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .pick   (pick_s),
    .any    (any_s)
  );

  // Encode the one-hot pick into an index so the pointer can advance past it.
  always_comb begin
    pick_idx_s = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_idx_s = pick_idx_s | (pick_s[i] ? PTR_W'(i) : {PTR_W{1'b0}});
    end
  end

  assign rr_ptr_next_s = (gnt_idx_q == PTR_LAST) ? {PTR_W{1'b0}} : (gnt_idx_q + PTR_W'(1));
  assign timeout_s     = (cnt_q == CNT_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a done on the last timeout cycle still completes normally.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          state_d = ST_CLR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLR: state_d = ST_RUN;
      ST_RUN: begin
        if (eng_done) begin
          state_d = ST_ACK;
        end else if (timeout_s) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; outputs are decoded from the next state
  // so they appear registered in the same cycle as the state they belong to.
  always_comb begin
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          gnt_d     = pick_s;
          gnt_idx_d = pick_idx_s;
        end else begin
          gnt_d = '0;
        end
      end
      ST_CLR: cnt_d = '0;
      ST_RUN: begin
        if (eng_done) begin
          res_d = eng_out;
        end else if (timeout_s) begin
          err_cnt_d = sat_inc8(err_cnt_q);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ACK, ST_ERR: begin
        gnt_d    = '0;
        rr_ptr_d = rr_ptr_next_s;
      end
      default: gnt_d = '0;
    endcase
    ack_d       = ((state_d == ST_ACK) || (state_d == ST_ERR)) ? gnt_d : '0;
    ack_err_d   = (state_d == ST_ERR);
    eng_rst_d   = (state_d == ST_CLR);
    eng_start_d = (state_d == ST_RUN);
  end

  // Output and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      ack_q       <= '0;
      ack_err_q   <= 1'b0;
      eng_rst_q   <= 1'b0;
      eng_start_q <= 1'b0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      err_cnt_q   <= 8'd0;
    end else begin
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      ack_q       <= ack_d;
      ack_err_q   <= ack_err_d;
      eng_rst_q   <= eng_rst_d;
      eng_start_q <= eng_start_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Route the granted requester's operands to the engine; zero when idle.
  always_comb begin
    eng_mat_a_s = '0;
    eng_wt_s    = '0;
    eng_bias_s  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int r = 0; r < MATRIX_SIZE; r++) begin
        eng_bias_s[r] = eng_bias_s[r] | ({DATA_WIDTH{gnt_q[i]}} & bus.bias[i][r]);
        for (int c = 0; c < MATRIX_SIZE; c++) begin
          eng_mat_a_s[r][c] = eng_mat_a_s[r][c] | ({DATA_WIDTH{gnt_q[i]}} & bus.mat_a[i][r][c]);
          eng_wt_s[r][c]    = eng_wt_s[r][c] | ({DATA_WIDTH{gnt_q[i]}} & bus.wt[i][r][c]);
        end
      end
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.ack     = ack_q;
  assign bus.ack_err = ack_err_q;
  assign res_matrix  = res_q;
  assign err_cnt     = err_cnt_q;
  assign eng_rst     = eng_rst_q;
  assign eng_start   = eng_start_q;
  assign eng_mat_a   = eng_mat_a_s;
  assign eng_wt      = eng_wt_s;
  assign eng_bias    = eng_bias_s;

endmodule

// File: tb/tb_linear_sched.sv
// Directed + randomized bench for linear_sched with a behavioural engine and
// a job-level reference model (round-robin order, capture, timeout count).
module tb_linear_sched;
  import attn_pkg::*;

  localparam int NR = 4;
  localparam int TO = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  linear_sched_if #(.NUM_REQ(NR)) bus ();

  matrix_t    res_matrix, eng_mat_a, eng_wt, eng_out;
  bias_t      eng_bias;
  logic [7:0] err_cnt;
  logic       eng_rst, eng_start, eng_done;

  linear_sched #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .res_matrix (res_matrix),
    .err_cnt    (err_cnt),
    .eng_rst    (eng_rst),
    .eng_start  (eng_start),
    .eng_mat_a  (eng_mat_a),
    .eng_wt     (eng_wt),
    .eng_bias   (eng_bias),
    .eng_done   (eng_done),
    .eng_out    (eng_out)
  );

  int      n_checks = 0;
  int      n_errors = 0;
  int      eng_lat;
  int      run_k;
  matrix_t job_out;
  int      m_ptr;
  int      m_err;
  matrix_t m_res;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_big(input string tag, input logic [4223:0] obs, input logic [4223:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed low word %0h expected low word %0h", tag, obs[31:0], exp[31:0]);
    end
  endtask

  task automatic rand_mat(output matrix_t m);
    for (int i = 0; i < MATRIX_SIZE; i++)
      for (int j = 0; j < MATRIX_SIZE; j++)
        m[i][j] = 8'($urandom);
  endtask

  // Behavioural engine: done after eng_lat cycles of start (0 = never);
  // outside a run it toggles done randomly with junk data.
  task automatic engine_step();
    logic [31:0] junk;
    junk = $urandom;
    if (eng_start) begin
      run_k++;
      if (eng_lat != 0 && run_k == eng_lat) begin
        eng_done = 1'b1;
        eng_out  = job_out;
      end else begin
        eng_done = 1'b0;
        eng_out  = {64{junk}};
      end
    end else begin
      run_k    = 0;
      eng_done = 1'($urandom_range(0, 1));
      eng_out  = {64{junk}};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    engine_step();
  endtask

  function automatic int rr_pick(input logic [NR-1:0] r, input int ptr);
    for (int k = 0; k < NR; k++)
      if (r[(ptr + k) % NR]) return (ptr + k) % NR;
    return -1;
  endfunction

  // One complete job starting from an IDLE cycle with requests pending.
  task automatic run_job(input int lat, input int drop_at, input bit keep_req,
                         input logic [NR-1:0] add_req, output int gi);
    int idx, runs, rst_pulses;
    bit got, exp_err, dropped;
    idx = rr_pick(bus.req, m_ptr);
    gi  = idx;
    if (idx < 0) return;
    eng_lat = lat;
    exp_err = (lat == 0) || (lat > TO);
    tick();
    chk("clr_gnt", bus.gnt, 64'(1) << idx);
    chk("clr_eng_rst", eng_rst, 1);
    chk("clr_eng_start", eng_start, 0);
    chk_big("operands", {eng_mat_a, eng_wt, eng_bias},
            {bus.mat_a[idx], bus.wt[idx], bus.bias[idx]});
    runs = 0; rst_pulses = 0; got = 1'b0; dropped = 1'b0;
    for (int c = 0; c < TO + 16 && !got; c++) begin
      tick();
      if (eng_rst) rst_pulses++;
      if (eng_start) runs++;
      if (drop_at != 0 && runs == drop_at && !dropped) begin
        bus.req[idx] = 1'b0;
        dropped = 1'b1;
      end
      if (bus.ack != '0) got = 1'b1;
    end
    chk("ack_seen", got, 1);
    chk("ack_onehot", bus.ack, 64'(1) << idx);
    chk("ack_err", bus.ack_err, exp_err);
    chk("run_cycles", runs, exp_err ? TO : lat);
    chk("eng_rst_single", rst_pulses, 0);
    if (!keep_req) bus.req[idx] = 1'b0;
    bus.req = bus.req | add_req;
    m_ptr = (idx + 1) % NR;
    if (exp_err) m_err = (m_err >= 255) ? 255 : m_err + 1;
    else         m_res = job_out;
    tick();
    chk("post_ack", bus.ack, 0);
    chk("post_ack_err", bus.ack_err, 0);
    chk("post_gnt", bus.gnt, 0);
    chk("post_err_cnt", err_cnt, m_err);
    chk_big("post_res", res_matrix, m_res);
    chk_big("idle_operands_zero", {eng_mat_a, eng_wt, eng_bias}, '0);
  endtask

  initial begin
    matrix_t tm;
    bias_t   tb_bias;
    int      gi, lat, drop;

    rst = 1'b0; bus.req = '0; eng_done = 1'b0; eng_out = '0;
    eng_lat = 0; run_k = 0; job_out = '0;
    m_ptr = 0; m_err = 0; m_res = '0;
    for (int r = 0; r < NR; r++) begin
      rand_mat(tm); bus.mat_a[r] = tm;
      rand_mat(tm); bus.wt[r] = tm;
      for (int i = 0; i < MATRIX_SIZE; i++) tb_bias[i] = 8'($urandom);
      bus.bias[r] = tb_bias;
    end

    // Reset values.
    tick(); tick();
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_ack_err", bus.ack_err, 0);
    chk("rst_eng_start", eng_start, 0);
    chk("rst_eng_rst", eng_rst, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk_big("rst_res", res_matrix, '0);
    rst = 1'b1;
    tick();
    chk("idle_gnt", bus.gnt, 0);

    // All four requesting continuously: strict rotation from index 0.
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      rand_mat(job_out);
      run_job($urandom_range(1, 6), 0, 1'b1, '0, gi);
      chk("rr_order", gi, k % 4);
    end
    bus.req = '0;
    tick();

    // Single requester 2, done after 10 run cycles with all-5 result.
    for (int i = 0; i < MATRIX_SIZE; i++)
      for (int j = 0; j < MATRIX_SIZE; j++)
        job_out[i][j] = 8'sd5;
    bus.req = 4'b0100;
    run_job(10, 0, 1'b0, '0, gi);
    chk("single_gnt_idx", gi, 2);

    // Requester 1 drops its request mid-run; job still completes.
    rand_mat(job_out);
    bus.req = 4'b0010;
    run_job(8, 3, 1'b0, '0, gi);
    chk("drop_gnt_idx", gi, 1);
    bus.req = 4'b0111;
    rand_mat(job_out);
    run_job(4, 0, 1'b0, '0, gi);
    chk("ptr_after_drop", gi, 2);

    // Randomized traffic with late arrivals and drops.
    for (int it = 0; it < 12; it++) begin
      if (bus.req == '0) bus.req = 4'($urandom_range(1, 15));
      rand_mat(job_out);
      lat  = $urandom_range(1, 20);
      drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, lat)) : 0;
      run_job(lat, drop, 1'b0, 4'($urandom_range(0, 15)), gi);
    end
    for (int it = 0; it < 8 && bus.req != '0; it++) begin
      rand_mat(job_out);
      run_job(3, 0, 1'b0, '0, gi);
    end
    bus.req = '0;
    tick();

    // Engine never finishes: timeout abort.
    rand_mat(job_out);
    bus.req = 4'b0001;
    run_job(0, 0, 1'b0, '0, gi);
    chk("timeout_err_cnt", err_cnt, 1);

    // Done arrives on the final timeout cycle: normal completion.
    rand_mat(job_out);
    bus.req = 4'b1000;
    run_job(TO, 0, 1'b0, '0, gi);
    chk("last_cycle_err_cnt", err_cnt, 1);

    // Reset during a run abandons the job; next job starts fresh.
    rand_mat(job_out);
    bus.req = 4'b0010;
    eng_lat = 50;
    tick();
    chk("pre_rst_clr", eng_rst, 1);
    for (int c = 0; c < 5; c++) tick();
    chk("pre_rst_running", eng_start, 1);
    rst = 1'b0;
    tick();
    chk("mid_rst_gnt", bus.gnt, 0);
    chk("mid_rst_ack", bus.ack, 0);
    chk("mid_rst_ack_err", bus.ack_err, 0);
    chk("mid_rst_eng_start", eng_start, 0);
    chk("mid_rst_eng_rst", eng_rst, 0);
    chk("mid_rst_err_cnt", err_cnt, 0);
    chk_big("mid_rst_res", res_matrix, '0);
    rst = 1'b1;
    m_ptr = 0; m_err = 0; m_res = '0;
    rand_mat(job_out);
    run_job(7, 0, 1'b0, '0, gi);
    chk("after_rst_gnt_idx", gi, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/linear_sched.md
LINEAR_SCHED -- requirements
Module: linear_sched

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one linear engine.
REQ-002 Parameter MATRIX_SIZE, 16, matrix dimension.
REQ-003 Parameter DATA_WIDTH, 8, signed element width.
REQ-004 Parameter TIMEOUT, 4096, max RUN cycles before abort.
REQ-005 clk  in  1  single clock, all logic on rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 req  in  NUM_REQ  level request per requester, held until its ack.
REQ-008 mat_a  in  NUM_REQ x MATRIX_SIZE x MATRIX_SIZE x DATA_WIDTH  per-requester operand A.
REQ-009 wt  in  NUM_REQ x MATRIX_SIZE x MATRIX_SIZE x DATA_WIDTH  per-requester weights.
REQ-010 bias  in  NUM_REQ x MATRIX_SIZE x DATA_WIDTH  per-requester bias.
REQ-011 gnt  out  NUM_REQ  one-hot grant, held for whole job.
REQ-012 ack  out  NUM_REQ  one-cycle completion pulse to granted requester.
REQ-013 ack_err  out  1  qualifies ack: job aborted by timeout.
REQ-014 res_matrix  out  MATRIX_SIZE x MATRIX_SIZE x DATA_WIDTH  last captured engine result.
REQ-015 err_cnt  out  8  saturating timeout count.
REQ-016 eng_rst  out  1  active-high one-cycle clear pulse to engine.
REQ-017 eng_start  out  1  engine start level.
REQ-018 eng_mat_a, eng_wt, eng_bias  out  engine operand widths  operands of granted requester.
REQ-019 eng_done  in  1  engine completion; eng_out valid while high.
REQ-020 eng_out  in  MATRIX_SIZE x MATRIX_SIZE x DATA_WIDTH  engine result.

Function
REQ-021 FSM states SHALL be IDLE, CLR, RUN, ACK, ERR.
REQ-022 IDLE: any req bit high -> register gnt from round-robin pick, go CLR; else stay.
REQ-023 Round-robin: search starts at pointer rr_ptr, lowest index at or after it wins, wraps NUM_REQ-1 -> 0.
REQ-024 CLR: eng_rst=1 for exactly one cycle, eng_start=0, timeout counter cleared; -> RUN.
REQ-025 RUN: eng_start=1; on edge with eng_done=1, res_matrix <= eng_out, -> ACK.
REQ-026 RUN: timeout counter increments each cycle; reaching TIMEOUT-1 without eng_done -> ERR; eng_done on that same cycle wins (-> ACK).
REQ-027 ACK: ack[granted]=1, ack_err=0 for one cycle; rr_ptr <= granted+1 (wrap); gnt cleared; -> IDLE.
REQ-028 ERR: ack[granted]=1, ack_err=1 one cycle; err_cnt +1 saturating at 255; res_matrix unchanged; rr_ptr advanced as ACK; -> IDLE.
REQ-029 eng_mat_a/eng_wt/eng_bias SHALL be combinational mux of granted requester inputs; all-zero when gnt=0.
REQ-030 Requester dropping req mid-job SHALL NOT abort; job completes and ack still pulses.
REQ-031 Request rising during ACK/ERR is served from IDLE next cycle; no combinational req-to-gnt path.
REQ-032 Job latency: req high in IDLE at edge n -> eng_rst at cycle n+1, eng_start from n+2, ack one cycle after eng_done edge.
REQ-033 eng_done outside RUN SHALL be ignored.

Reset
REQ-034 rst=0 at clock edge: state IDLE, gnt=0, ack=0, ack_err=0, eng_start=0, eng_rst=0, rr_ptr=0, err_cnt=0, res_matrix all zero, counter zero.
REQ-035 Reset mid-job SHALL abandon job with no ack; next job begins with CLR pulse.

Structure
REQ-036 Shared package attn_pkg SHALL hold DATA_WIDTH, MATRIX_SIZE, matrix and bias typedefs, and sched state enum.
REQ-037 One sub-module rr_arbiter (req, rr_ptr -> one-hot pick, any) SHALL be instantiated.

Verification
REQ-038 Single req[2], engine done after 10 RUN cycles with eng_out=all 5 -> gnt=0100, one eng_rst pulse, ack[2] one cycle, res_matrix all 5.
REQ-039 req=1111 held continuously -> grants in order 0,1,2,3,0; no requester granted twice before others.
REQ-040 Engine never asserts done -> ERR after TIMEOUT cycles, ack_err=1 with ack, err_cnt=1, res_matrix unchanged.
REQ-041 eng_done on final timeout cycle -> ACK path, ack_err=0, err_cnt unchanged.
REQ-042 rst low during RUN -> all outputs to reset values, no ack; following req produces fresh CLR pulse and normal completion.
REQ-043 req[1] dropped mid-RUN -> job finishes, ack[1] pulses, rr_ptr=2.
